cvt_timing_gen: RTL and testbench

- CVT raster timing generator; the transmit-side counterpart of the CVT timing detector.
- Given programmed horizontal/vertical timings, polarities and an interlace flag, it drives hsync/vsync/de/field for a set number of frames.
- A detector fed by these signals measures back the same frame height, hfreq, vsync width and polarities.
- Uses the same start/busy/done/stall call handshake as the other accelerator blocks.

---
 rtl/cvt_gen_pkg.sv | 43 ++++
 rtl/cvt_axis_counter.sv | 51 +++++
 rtl/cvt_timing_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_cvt_timing_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvt_gen_pkg.sv
// Shared types for the CVT raster timing generator: FSM states, polarity bit
// positions and the latched configuration record.
package cvt_gen_pkg;

   localparam int CFG_CW        = 16;
   localparam int VSYNC_POS_POL = 0;
   localparam int HSYNC_POS_POL = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [CFG_CW-1:0] h_active;
      logic [CFG_CW-1:0] h_fp;
      logic [CFG_CW-1:0] h_sync;
      logic [CFG_CW-1:0] h_bp;
      logic [CFG_CW-1:0] v_active;
      logic [CFG_CW-1:0] v_fp;
      logic [CFG_CW-1:0] v_sync;
      logic [CFG_CW-1:0] v_bp;
      logic [1:0]        polarities;
      logic              interlaced;
   } cvt_cfg_t;

   // Both polarities positive so the idle sync level comes out as 0.
   localparam cvt_cfg_t CFG_RESET = '{
      h_active:   {CFG_CW{1'b0}},
      h_fp:       {CFG_CW{1'b0}},
      h_sync:     {CFG_CW{1'b0}},
      h_bp:       {CFG_CW{1'b0}},
      v_active:   {CFG_CW{1'b0}},
      v_fp:       {CFG_CW{1'b0}},
      v_sync:     {CFG_CW{1'b0}},
      v_bp:       {CFG_CW{1'b0}},
      polarities: 2'b11,
      interlaced: 1'b0
   };

endpackage

// File: rtl/cvt_axis_counter.sv
// One raster axis: counts through active, front porch, sync and back porch
// regions and flags the wrap plus active/sync region membership.
module cvt_axis_counter #(
   parameter int CW = 16
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          clear,
   input  logic          en,
   input  logic [CW-1:0] active,
   input  logic [CW-1:0] fp,
   input  logic [CW-1:0] sync,
   input  logic [CW-1:0] bp,
   input  logic          extra_line,
   output logic [CW+1:0] pos,
   output logic          wrap,
   output logic          in_active,
   output logic          in_sync
);

   localparam int SW = CW + 2;

   logic [SW-1:0] pos_r;
   logic [SW-1:0] sync_start_s;
   logic [SW-1:0] sync_end_s;
   logic [SW-1:0] total_s;

   // Region boundaries are summed two bits wider so four full-scale fields fit.
   assign sync_start_s = SW'(active) + SW'(fp);
   assign sync_end_s   = sync_start_s + SW'(sync);
   assign total_s      = sync_end_s + SW'(bp) + SW'(extra_line);

   assign pos       = pos_r;
   assign wrap      = en && (pos_r == (total_s - SW'(1'b1)));
   assign in_active = (pos_r < SW'(active));
   assign in_sync   = (pos_r >= sync_start_s) && (pos_r < sync_end_s);

   // Position register: cleared before each run, advances when enabled.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         pos_r <= {SW{1'b0}};
      end else if (clear || wrap) begin
         pos_r <= {SW{1'b0}};
      end else if (en) begin
         pos_r <= pos_r + SW'(1'b1);
      end else begin
         pos_r <= pos_r;
      end
   end

endmodule

// File: rtl/cvt_timing_gen.sv
// CVT raster timing generator with start/busy/done/stall call handshake.
// Optional interlaced fields are built in when CVT_GEN_INTERLACE_EN is defined.
module cvt_timing_gen
   import cvt_gen_pkg::*;
#(
   parameter int CW  = 16,
   parameter int FCW = 16
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           start,
   output logic           busy,
   output logic           done,
   input  logic           stall,
   output logic           returndata,
   input  logic [CW-1:0]  h_active,
   input  logic [CW-1:0]  h_fp,
   input  logic [CW-1:0]  h_sync,
   input  logic [CW-1:0]  h_bp,
   input  logic [CW-1:0]  v_active,
   input  logic [CW-1:0]  v_fp,
   input  logic [CW-1:0]  v_sync,
   input  logic [CW-1:0]  v_bp,
   input  logic [1:0]     polarities,
   input  logic           interlaced,
   input  logic [FCW-1:0] frame_count,
   input  logic           stop,
   output logic           hsync,
   output logic           vsync,
   output logic           de,
   output logic           field,
   output logic           frame_start
);

   localparam int SW = CW + 2;

   state_t         state_r, state_s;
   cvt_cfg_t       cfg_r;
   logic [FCW-1:0] frame_max_r, frame_cnt_r;
   logic           stop_seen_r, field_r;
   logic           busy_r, done_r, retdata_r;
   logic           hsync_r, vsync_r, de_r, field_out_r, frame_start_r;

   logic [SW-1:0]  h_pos_s, v_pos_s;
   logic           h_wrap_s, v_wrap_s, h_act_s, v_act_s, h_sync_s, v_sync_s;
   logic           run_s, clear_s, interlace_on_s, extra_line_s, vs_act_s;
   logic           frame_end_s, last_frame_s, cfg_err_s;

   assign run_s   = (state_r == RUN);
   assign clear_s = (state_r == CHECK);

   assign cfg_err_s = (cfg_r.h_active == {CFG_CW{1'b0}}) || (cfg_r.h_sync == {CFG_CW{1'b0}}) ||
                      (cfg_r.v_active == {CFG_CW{1'b0}}) || (cfg_r.v_sync == {CFG_CW{1'b0}});

   cvt_axis_counter #(.CW(CW)) u_h_cnt (
      .clock      (clock),
      .resetn     (resetn),
      .clear      (clear_s),
      .en         (run_s),
      .active     (CW'(cfg_r.h_active)),
      .fp         (CW'(cfg_r.h_fp)),
      .sync       (CW'(cfg_r.h_sync)),
      .bp         (CW'(cfg_r.h_bp)),
      .extra_line (1'b0),
      .pos        (h_pos_s),
      .wrap       (h_wrap_s),
      .in_active  (h_act_s),
      .in_sync    (h_sync_s)
   );

   cvt_axis_counter #(.CW(CW)) u_v_cnt (
      .clock      (clock),
      .resetn     (resetn),
      .clear      (clear_s),
      .en         (run_s && h_wrap_s),
      .active     (CW'(cfg_r.v_active)),
      .fp         (CW'(cfg_r.v_fp)),
      .sync       (CW'(cfg_r.v_sync)),
      .bp         (CW'(cfg_r.v_bp)),
      .extra_line (extra_line_s),
      .pos        (v_pos_s),
      .wrap       (v_wrap_s),
      .in_active  (v_act_s),
      .in_sync    (v_sync_s)
   );

`ifdef CVT_GEN_INTERLACE_EN
   logic [SW-1:0] half_s, vs_start_s, vs_end_s;

   assign interlace_on_s = cfg_r.interlaced;
   assign extra_line_s   = field_r;
   assign half_s     = (SW'(cfg_r.h_active) + SW'(cfg_r.h_fp) + SW'(cfg_r.h_sync) + SW'(cfg_r.h_bp)) >> 1;
   assign vs_start_s = SW'(cfg_r.v_active) + SW'(cfg_r.v_fp);
   assign vs_end_s   = vs_start_s + SW'(cfg_r.v_sync);

   // Second field moves both vsync edges to the middle of the line.
   always_comb begin
      vs_act_s = v_sync_s;
      if (field_r) begin
         vs_act_s = (v_sync_s && !((v_pos_s == vs_start_s) && (h_pos_s < half_s))) ||
                    ((v_pos_s == vs_end_s) && (h_pos_s < half_s));
      end else begin
         vs_act_s = v_sync_s;
      end
   end
`else
   logic unused_s;

   assign interlace_on_s = 1'b0;
   assign extra_line_s   = 1'b0;
   assign vs_act_s       = v_sync_s;
   assign unused_s       = interlaced ^ cfg_r.interlaced;
`endif

   // An interlaced frame ends only after its second field.
   assign frame_end_s  = v_wrap_s && (!interlace_on_s || field_r);
   assign last_frame_s = (frame_max_r != {FCW{1'b0}}) && (frame_cnt_r == (frame_max_r - FCW'(1'b1)));

   // Next-state logic for the call FSM.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = CHECK;
            else       state_s = IDLE;
         end
         CHECK: begin
            if (cfg_err_s) state_s = DONE;
            else           state_s = RUN;
         end
         RUN: begin
            if (frame_end_s && (last_frame_s || stop_seen_r)) state_s = DONE;
            else                                              state_s = RUN;
         end
         DONE: begin
            if (!stall) state_s = IDLE;
            else        state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!resetn) state_r <= IDLE;
      else         state_r <= state_s;
   end

   // Handshake flags, latched configuration and frame/stop bookkeeping.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         retdata_r   <= 1'b0;
         cfg_r       <= CFG_RESET;
         frame_max_r <= {FCW{1'b0}};
         frame_cnt_r <= {FCW{1'b0}};
         stop_seen_r <= 1'b0;
         field_r     <= 1'b0;
      end else begin
         busy_r <= (state_s != IDLE);
         done_r <= (state_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  cfg_r <= '{h_active: CFG_CW'(h_active), h_fp: CFG_CW'(h_fp),
                             h_sync: CFG_CW'(h_sync), h_bp: CFG_CW'(h_bp),
                             v_active: CFG_CW'(v_active), v_fp: CFG_CW'(v_fp),
                             v_sync: CFG_CW'(v_sync), v_bp: CFG_CW'(v_bp),
                             polarities: polarities, interlaced: interlaced};
                  frame_max_r <= frame_count;
               end
            end
            CHECK: begin
               retdata_r   <= !cfg_err_s;
               frame_cnt_r <= {FCW{1'b0}};
               stop_seen_r <= 1'b0;
               field_r     <= 1'b0;
            end
            RUN: begin
               // A stop on the wrap cycle itself belongs to the following frame.
               if (frame_end_s) begin
                  frame_cnt_r <= frame_cnt_r + FCW'(1'b1);
                  stop_seen_r <= stop;
               end else begin
                  stop_seen_r <= stop_seen_r | stop;
               end
               if (v_wrap_s && interlace_on_s) field_r <= ~field_r;
            end
            DONE: begin
               if (!stall) cfg_r.polarities <= 2'b11;
            end
            default: ;
         endcase
      end
   end

   // Raster outputs, one cycle behind the counters; inactive levels outside RUN.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         hsync_r       <= 1'b0;
         vsync_r       <= 1'b0;
         de_r          <= 1'b0;
         field_out_r   <= 1'b0;
         frame_start_r <= 1'b0;
      end else if (run_s) begin
         hsync_r       <= ~(h_sync_s ^ cfg_r.polarities[HSYNC_POS_POL]);
         vsync_r       <= ~(vs_act_s ^ cfg_r.polarities[VSYNC_POS_POL]);
         de_r          <= h_act_s && v_act_s;
         field_out_r   <= field_r;
         frame_start_r <= (h_pos_s == {SW{1'b0}}) && (v_pos_s == {SW{1'b0}});
      end else begin
         hsync_r       <= ~cfg_r.polarities[HSYNC_POS_POL];
         vsync_r       <= ~cfg_r.polarities[VSYNC_POS_POL];
         de_r          <= 1'b0;
         field_out_r   <= 1'b0;
         frame_start_r <= 1'b0;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign returndata  = retdata_r;
   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign de          = de_r;
   assign field       = field_out_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_cvt_timing_gen.sv
// Directed self-checking bench for cvt_timing_gen; sample index i means the
// falling edge after the i-th rising edge following the start-accept edge.
module tb_cvt_timing_gen;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0, stall = 1'b0, stop = 1'b0;
   logic        busy, done, returndata;
   logic [15:0] h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp;
   logic [1:0]  polarities;
   logic        interlaced;
   logic [15:0] frame_count;
   logic        hsync, vsync, de, field, frame_start;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   cvt_timing_gen #(.CW(16), .FCW(16)) dut (
      .clock(clock), .resetn(resetn), .start(start), .busy(busy), .done(done),
      .stall(stall), .returndata(returndata),
      .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
      .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
      .polarities(polarities), .interlaced(interlaced), .frame_count(frame_count),
      .stop(stop), .hsync(hsync), .vsync(vsync), .de(de), .field(field),
      .frame_start(frame_start)
   );

   task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb,
                          input logic [1:0] pol, input logic il, input int fc);
      h_active = 16'(ha); h_fp = 16'(hf); h_sync = 16'(hs); h_bp = 16'(hb);
      v_active = 16'(va); v_fp = 16'(vf); v_sync = 16'(vs); v_bp = 16'(vb);
      polarities = pol; interlaced = il; frame_count = 16'(fc);
   endtask

   // Leaves the bench on the falling edge right after the accepting edge.
   task automatic pulse_start;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      total++;
      if ({busy, done, returndata, hsync, vsync, de, field, frame_start} !== 8'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=00000000",
                  {busy, done, returndata, hsync, vsync, de, field, frame_start});
      end
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      total++;
      if ({busy, hsync, vsync, de} !== 4'b0) begin
         bad++;
         $display("FAIL reset_idle got=%b exp=0000", {busy, hsync, vsync, de});
      end
   endtask

   task automatic test_progressive;
      int c, h, v;
      logic [3:0] exp_v;
      set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 2'b11, 1'b0, 2);
      pulse_start;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clock);
         if (i == 1) begin
            total++;
            if ({busy, de} !== 2'b10) begin
               bad++;
               $display("FAIL prog_first got busy,de=%b exp=10", {busy, de});
            end
         end
         if (i >= 2 && i <= 97) begin
            c = i - 2; h = c % 8; v = (c / 8) % 6;
            exp_v = {(h < 4) && (v < 3), (h >= 5) && (h < 7), v == 4, (h == 0) && (v == 0)};
            total++;
            if ({de, hsync, vsync, frame_start} !== exp_v) begin
               bad++;
               $display("FAIL prog_raster i=%0d got=%b exp=%b", i, {de, hsync, vsync, frame_start}, exp_v);
            end
         end
         if (i == 96 || i == 97) begin
            total++;
            if (done !== (i == 97) || (i == 97 && returndata !== 1'b1)) begin
               bad++;
               $display("FAIL prog_done i=%0d got done=%b ret=%b exp done=%b ret=1", i, done, returndata, i == 97);
            end
         end
         if (i == 98) begin
            total++;
            if ({busy, done} !== 2'b00) begin
               bad++;
               $display("FAIL prog_release got busy,done=%b exp=00", {busy, done});
            end
         end
      end
   endtask

   task automatic test_polarity;
      int c, h, v;
      logic [1:0] exp_s;
      set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 2'b00, 1'b0, 2);
      pulse_start;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clock);
         if (i >= 2 && i <= 97) begin
            c = i - 2; h = c % 8; v = (c / 8) % 6;
            exp_s = {!((h >= 5) && (h < 7)), !(v == 4)};
            total++;
            if ({hsync, vsync} !== exp_s) begin
               bad++;
               $display("FAIL pol_raster i=%0d got=%b exp=%b", i, {hsync, vsync}, exp_s);
            end
         end
         if (i == 98 || i == 100) begin
            exp_s = (i == 98) ? 2'b11 : 2'b00;
            total++;
            if ({hsync, vsync} !== exp_s) begin
               bad++;
               $display("FAIL pol_after_done i=%0d got=%b exp=%b", i, {hsync, vsync}, exp_s);
            end
         end
      end
   endtask

   task automatic test_config_error;
      set_cfg(4, 1, 0, 1, 3, 1, 1, 1, 2'b11, 1'b0, 1);
      pulse_start;
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) @(negedge clock);
         total++;
         if ({hsync, vsync, de} !== 3'b000) begin
            bad++;
            $display("FAIL cfgerr_quiet i=%0d got=%b exp=000", i, {hsync, vsync, de});
         end
         if (i == 1) begin
            total++;
            if ({done, returndata} !== 2'b10) begin
               bad++;
               $display("FAIL cfgerr_done got done,ret=%b exp=10", {done, returndata});
            end
         end
         if (i == 2) begin
            total++;
            if ({busy, done} !== 2'b00) begin
               bad++;
               $display("FAIL cfgerr_release got busy,done=%b exp=00", {busy, done});
            end
         end
      end
   endtask

   task automatic test_stop_stall;
      set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 2'b11, 1'b0, 0);
      stall = 1'b1;
      pulse_start;
      for (int i = 1; i <= 58; i++) begin
         @(negedge clock);
         if (i == 48) begin
            total++;
            if (done !== 1'b0) begin
               bad++;
               $display("FAIL stop_early got done=%b exp=0", done);
            end
         end
         if (i >= 49 && i <= 53) begin
            total++;
            if ({done, returndata, busy} !== 3'b111) begin
               bad++;
               $display("FAIL stop_hold i=%0d got done,ret,busy=%b exp=111", i, {done, returndata, busy});
            end
         end
         if (i == 54 || i == 56) begin
            total++;
            if ({busy, done} !== 2'b00) begin
               bad++;
               $display("FAIL stop_release i=%0d got busy,done=%b exp=00", i, {busy, done});
            end
         end
         stop  = (i == 31);
         start = (i == 50);
         if (i == 53) stall = 1'b0;
      end
      start = 1'b0;
      stop  = 1'b0;
      stall = 1'b0;
   endtask

   task automatic test_reset_mid_run;
      int de_cnt;
      set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 2'b11, 1'b0, 0);
      pulse_start;
      repeat (20) @(negedge clock);
      total++;
      if (de !== 1'b1) begin
         bad++;
         $display("FAIL midrst_before got de=%b exp=1", de);
      end
      resetn = 1'b0;
      @(negedge clock);
      total++;
      if ({busy, done, returndata, hsync, vsync, de, field, frame_start} !== 8'b0) begin
         bad++;
         $display("FAIL midrst_outputs got=%b exp=00000000",
                  {busy, done, returndata, hsync, vsync, de, field, frame_start});
      end
      resetn = 1'b1;
      set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 2'b11, 1'b0, 1);
      pulse_start;
      de_cnt = 0;
      for (int i = 1; i <= 52; i++) begin
         @(negedge clock);
         if (de === 1'b1) de_cnt++;
         if (i == 2) begin
            total++;
            if ({de, frame_start} !== 2'b11) begin
               bad++;
               $display("FAIL midrst_restart got de,fs=%b exp=11", {de, frame_start});
            end
         end
         if (i == 48 || i == 49) begin
            total++;
            if (done !== (i == 49)) begin
               bad++;
               $display("FAIL midrst_done i=%0d got=%b exp=%b", i, done, i == 49);
            end
         end
      end
      total++;
      if (de_cnt != 12) begin
         bad++;
         $display("FAIL midrst_de_count got=%0d exp=12", de_cnt);
      end
   endtask

`ifdef CVT_GEN_INTERLACE_EN
   task automatic test_interlace;
      set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 2'b11, 1'b1, 1);
      pulse_start;
      for (int i = 1; i <= 108; i++) begin
         @(negedge clock);
         if (i == 49 || i == 50 || i == 104) begin
            total++;
            if (field !== (i != 49)) begin
               bad++;
               $display("FAIL il_field i=%0d got=%b exp=%b", i, field, i != 49);
            end
         end
         if (i == 2 || i == 50) begin
            total++;
            if (frame_start !== 1'b1) begin
               bad++;
               $display("FAIL il_frame_start i=%0d got=0 exp=1", i);
            end
         end
         if (i == 33 || i == 34 || i == 41 || i == 42 || i == 85 || i == 86 || i == 93 || i == 94) begin
            total++;
            if (vsync !== (i == 34 || i == 41 || i == 86 || i == 93)) begin
               bad++;
               $display("FAIL il_vsync i=%0d got=%b exp=%b", i, vsync, i == 34 || i == 41 || i == 86 || i == 93);
            end
         end
         if (i == 104 || i == 105) begin
            total++;
            if (done !== (i == 105)) begin
               bad++;
               $display("FAIL il_done i=%0d got=%b exp=%b", i, done, i == 105);
            end
         end
      end
   endtask
`else
   task automatic test_interlace;
      set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 2'b11, 1'b1, 1);
      pulse_start;
      for (int i = 1; i <= 52; i++) begin
         @(negedge clock);
         total++;
         if (field !== 1'b0) begin
            bad++;
            $display("FAIL prog_only_field i=%0d got=%b exp=0", i, field);
         end
         if (i == 48 || i == 49) begin
            total++;
            if (done !== (i == 49)) begin
               bad++;
               $display("FAIL prog_only_done i=%0d got=%b exp=%b", i, done, i == 49);
            end
         end
      end
   endtask
`endif

   initial begin
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 0);
      test_reset;
      test_progressive;
      test_polarity;
      test_config_error;
      test_stop_stall;
      test_reset_mid_run;
      test_interlace;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
